// File: rtl/idct_block_arbiter_if.sv
// Row-stream and IDCT-core handshake bundle for idct_block_arbiter.
// slave is the arbiter's view; master is the requesters/core side.
interface idct_block_arbiter_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IDW = 2,
    parameter int unsigned WIN = 16
);
    logic [NCH*8*WIN-1:0] s_tdata;
    logic [NCH-1:0]       s_tvalid;
    logic [NCH-1:0]       s_tready;
    logic [8*WIN-1:0]     core_in;
    logic                 core_valid;
    logic                 core_ready;
    logic                 core_done;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic                 busy;
    logic                 err;

    modport slave (
        input  s_tdata, s_tvalid, core_ready, core_done,
        output s_tready, core_in, core_valid, done, done_id, busy, err
    );

    modport master (
        output s_tdata, s_tvalid, core_ready, core_done,
        input  s_tready, core_in, core_valid, done, done_id, busy, err
    );
endinterface

// File: rtl/idct_block_arbiter.sv
// Round-robin block scheduler sharing one IDCT core among NCH row streams;
// tags each in-flight block with its channel and reports it on core_done.
module idct_block_arbiter #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned WIN  = 16,
    parameter int unsigned TAGD = 2
) (
    input logic                clock,
    input logic                reset_n,
    idct_block_arbiter_if.slave bus
);
    localparam int unsigned RW = 8 * WIN;
    localparam int unsigned AW = $clog2(TAGD);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [2:0]     beat_q, beat_d;
    logic [IDW-1:0] pick, cand;
    logic           found;

    logic [IDW-1:0] tag_mem [TAGD];
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full;
    logic           push, pop, beat;

    logic           done_q;
    logic [IDW-1:0] done_id_q;
    logic           err_q;

    logic [RW-1:0]  core_in;
    logic           core_valid;
    logic [NCH-1:0] s_tready;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = bus.core_done && !fifo_empty;

    // First requester after the last served channel, wrapping modulo NCH.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = IDW'((32'(last_q) + i) % NCH);
            if (!found && bus.s_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_d     = beat_q;
        push       = 1'b0;
        core_in    = '0;
        core_valid = 1'b0;
        s_tready   = '0;
        beat       = (state_q == StBurst) && bus.s_tvalid[grant_q] && bus.core_ready;
        unique case (state_q)
            StIdle: begin
                if (found && !fifo_full) begin
                    grant_d = pick;
                    beat_d  = 3'd0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                core_in           = bus.s_tdata[32'(grant_q) * RW +: RW];
                core_valid        = bus.s_tvalid[grant_q];
                s_tready[grant_q] = bus.core_ready;
                if (beat) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        push    = 1'b1;
                        last_d  = grant_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= IDW'(NCH - 1);
            beat_q    <= 3'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            done_q  <= bus.core_done;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                done_id_q <= tag_mem[rd_ptr_q[AW-1:0]];
            end
            if (bus.core_done && fifo_empty) err_q <= 1'b1;
        end
    end

    // Tag storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) tag_mem[wr_ptr_q[AW-1:0]] <= grant_q;
    end

    assign bus.core_in    = core_in;
    assign bus.core_valid = core_valid;
    assign bus.s_tready   = s_tready;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.busy       = (state_q == StBurst) || !fifo_empty;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_idct_block_arbiter.sv
// Bench for idct_block_arbiter: queue-based block model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_idct_block_arbiter;
    localparam int unsigned NCH  = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned WIN  = 16;
    localparam int unsigned TAGD = 2;
    localparam int unsigned RW   = 8 * WIN;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    idct_block_arbiter_if #(.NCH(NCH), .IDW(IDW), .WIN(WIN)) bus ();

    idct_block_arbiter #(.NCH(NCH), .IDW(IDW), .WIN(WIN), .TAGD(TAGD)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Model: owner of the core (-1 none), rows moved, last served, tags in flight.
    int m_owner = -1;
    int m_rows  = 0;
    int m_last  = NCH - 1;
    int m_tags[$];
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;
    int m_done_id = 0;
    int m_grant_log[$];
    int dut_done_log[$];
    int beat_count = 0;
    int n0, fin;
    bit blk_done;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        for (int w = 0; w < int'(NCH * 8); w++) bus.s_tdata[w*WIN +: WIN] = WIN'($urandom);
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic reset_dut();
        reset_n       = 1'b0;
        bus.s_tvalid  = '0;
        bus.core_done = 1'b0;
        bus.core_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            m_owner = -1; m_rows = 0; m_last = NCH - 1;
            m_tags.delete();
            m_done = 1'b0; m_done_id = 0; m_err = 1'b0;
        end else begin
            n0 = m_tags.size();
            blk_done = 1'b0;
            if (m_owner < 0) begin
                if (bus.s_tvalid != '0 && n0 < int'(TAGD)) begin
                    for (int k = 1; k <= int'(NCH); k++) begin
                        if (m_owner < 0 && bus.s_tvalid[(m_last + k) % NCH]) begin
                            m_owner = (m_last + k) % NCH;
                            m_grant_log.push_back(m_owner);
                        end
                    end
                    m_rows = 0;
                end
            end else if (bus.s_tvalid[m_owner] && bus.core_ready) begin
                m_rows++;
                if (m_rows == 8) begin
                    blk_done = 1'b1; fin = m_owner; m_last = m_owner; m_owner = -1;
                end
            end
            m_done = bus.core_done;
            if (bus.core_done) begin
                if (n0 > 0) m_done_id = m_tags.pop_front();
                else m_err = 1'b1;
            end
            if (blk_done) m_tags.push_back(fin);
        end
    end

    logic [NCH-1:0] e_tready;
    logic [RW-1:0]  e_core_in;
    logic           e_valid;

    always @(negedge clock) begin
        if (check_en) begin
            e_tready  = '0;
            e_core_in = '0;
            e_valid   = 1'b0;
            if (m_owner >= 0) begin
                e_tready[m_owner] = bus.core_ready;
                e_core_in = bus.s_tdata[m_owner*RW +: RW];
                e_valid   = bus.s_tvalid[m_owner];
            end
            chk("s_tready", bus.s_tready, e_tready);
            chk("core_valid", bus.core_valid, e_valid);
            chk("core_in", bus.core_in, e_core_in);
            chk("done", bus.done, m_done);
            chk("done_id", bus.done_id, m_done_id);
            chk("busy", bus.busy, (m_owner >= 0) || (m_tags.size() > 0));
            chk("err", bus.err, m_err);
            if (bus.done) dut_done_log.push_back(int'(bus.done_id));
            if (bus.core_valid && bus.core_ready) beat_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end by 200000");
        $fatal(1);
    end

    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        bus.s_tdata = '0;
        bus.s_tvalid = '0;
        bus.core_ready = 1'b1;
        bus.core_done = 1'b0;

        // Single block on ch2
        reset_dut();
        check_en = 1'b1;
        at_neg();
        chk("reset busy", bus.busy, 0);
        chk("reset err", bus.err, 0);
        chk("reset s_tready", bus.s_tready, 0);
        beat_count = 0;
        bus.s_tvalid = 4'b0100;
        tick();
        at_neg();
        chk("t1 grant ch2", bus.s_tready, 4'b0100);
        repeat (8) tick();
        bus.s_tvalid = '0;
        at_neg();
        chk("t1 back to idle", bus.s_tready, 0);
        chk("t1 busy pending", bus.busy, 1);
        chk("t1 beats", beat_count, 8);
        repeat (9) tick();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        at_neg();
        chk("t1 done", bus.done, 1);
        chk("t1 done_id", bus.done_id, 2);
        chk("t1 busy low", bus.busy, 0);
        tick();
        at_neg();
        chk("t1 done pulse", bus.done, 0);

        // All channels requesting for 8 blocks
        reset_dut();
        m_grant_log.delete();
        dut_done_log.delete();
        beat_count = 0;
        bus.s_tvalid = 4'hF;
        for (int t = 1; t <= 84; t++) begin
            tick();
            bus.core_done = (t >= 13) && (t % 9 == 4);
            if (t == 72) bus.s_tvalid = '0;
        end
        at_neg();
        chk("t2 beats", beat_count, 64);
        chk("t2 grants", m_grant_log.size(), 8);
        chk("t2 dones", dut_done_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < m_grant_log.size()) chk("t2 model grant", m_grant_log[i], exp_seq[i]);
            if (i < dut_done_log.size()) chk("t2 done_id seq", dut_done_log[i], exp_seq[i]);
        end

        // Backpressure on ch1
        reset_dut();
        beat_count = 0;
        bus.s_tvalid = 4'b0010;
        tick();
        for (int i = 1; i <= 15; i++) begin
            bus.core_ready = (i % 2 == 1);
            tick();
        end
        bus.s_tvalid = '0;
        bus.core_ready = 1'b1;
        at_neg();
        chk("t3 beats", beat_count, 8);
        chk("t3 idle", bus.s_tready, 0);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        at_neg();
        chk("t3 done_id", bus.done_id, 1);

        // Tag FIFO full
        reset_dut();
        bus.s_tvalid = 4'b0111;
        repeat (20) tick();
        at_neg();
        chk("t4 stalled tready", bus.s_tready, 0);
        chk("t4 stalled valid", bus.core_valid, 0);
        chk("t4 busy", bus.busy, 1);
        repeat (5) tick();
        at_neg();
        chk("t4 still stalled", bus.s_tready, 0);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        at_neg();
        chk("t4 done", bus.done, 1);
        chk("t4 first id", bus.done_id, 0);
        chk("t4 no grant yet", bus.s_tready, 0);
        tick();
        at_neg();
        chk("t4 third grant", bus.s_tready, 4'b0100);
        repeat (8) tick();
        bus.s_tvalid = '0;
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        at_neg();
        chk("t4 second id", bus.done_id, 1);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        at_neg();
        chk("t4 third id", bus.done_id, 2);
        chk("t4 drained", bus.busy, 0);

        // Mid-block reset, then spurious core_done
        reset_dut();
        bus.s_tvalid = 4'b1000;
        tick();
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        at_neg();
        chk("t5 rst tready", bus.s_tready, 0);
        chk("t5 rst valid", bus.core_valid, 0);
        chk("t5 rst core_in", bus.core_in, 0);
        chk("t5 rst busy", bus.busy, 0);
        chk("t5 rst done", bus.done, 0);
        chk("t5 rst done_id", bus.done_id, 0);
        reset_n = 1'b1;
        bus.s_tvalid = 4'b1001;
        tick();
        at_neg();
        chk("t5 restart ch0", bus.s_tready, 4'b0001);
        bus.s_tvalid = '0;
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        at_neg();
        chk("t5 err set", bus.err, 1);
        chk("t5 done pulse", bus.done, 1);
        chk("t5 done_id held", bus.done_id, 0);
        tick();
        at_neg();
        chk("t5 err sticky", bus.err, 1);
        chk("t5 done low", bus.done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/idct_block_arbiter.md
Name: idct_block_arbiter

Overview:
- Round-robin scheduler that shares one wide IDCT core (row-per-beat input, 8 beats per 8x8 block, `done` pulse per block) among NCH independent row-stream requesters.
- Grants a requester for exactly one whole block (8 accepted rows), muxes its rows onto the core input, and tags each completed block with the originating channel ID.
- Sits between the per-channel input ports and the shared IDCT core. Downstream logic uses `done_id` to route each finished 8x8 result.

Parameters:
- NCH, 4, number of requesters (2..8).
- IDW, 2, channel-ID width, = ceil(log2(NCH)).
- WIN, 16, width of one input coefficient. A row is 8*WIN bits.
- TAGD, 2, depth of the in-flight tag FIFO (power of 2).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- s_tdata  in  NCH*8*WIN  row data; channel c occupies bits [(c+1)*8*WIN-1 : c*8*WIN]
- s_tvalid  in  NCH  per-channel row valid
- s_tready  out  NCH  per-channel row accept
- core_in  out  8*WIN  row to IDCT core
- core_valid  out  1  row valid to core
- core_ready  in  1  core can accept rows
- core_done  in  1  one-cycle pulse: core finished a block
- done  out  1  one-cycle pulse, registered copy of core_done
- done_id  out  IDW  channel of the block reported by `done`
- busy  out  1  high when state=BURST or the tag FIFO is non-empty
- err  out  1  sticky: core_done arrived with the tag FIFO empty

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, grant=0, last=NCH-1, beat_cnt=0, tag FIFO emptied, done=0, done_id=0, err=0.
  - Any partially transferred block is abandoned.
  - All outputs are 0 from the cycle after reset.
- Beat definition: a beat is a cycle in BURST with s_tvalid[grant] & core_ready.
- State IDLE:
  - core_valid=0 and s_tready=0.
  - If any s_tvalid bit is set and the tag FIFO is not full, grant <= the first requesting channel searched from last+1, wrapping modulo NCH. Then beat_cnt<=0 and state<=BURST.
  - Arbitration costs exactly one cycle, so there is a 1-cycle bubble between consecutive blocks.
- State BURST:
  - core_in = s_tdata slice of grant.
  - core_valid = s_tvalid[grant].
  - s_tready[grant] = core_ready; all other s_tready bits are 0.
  - Combinational path from core_ready to s_tready is allowed. No combinational path exists from s_tvalid to core_ready.
  - Each beat increments beat_cnt.
  - On the beat with beat_cnt=7: push grant into the tag FIFO, last<=grant, state<=IDLE.
  - If the requester drops s_tvalid mid-block, the grant is held and the core stalls. There is no timeout and no preemption.
- Round-robin fairness: a channel that was just served has the lowest priority next arbitration. With all channels requesting continuously, grant order is 0,1,2,3,0,…
- Tag FIFO:
  - Push on block completion; pop on core_done.
  - Simultaneous push and pop in the same cycle are both performed and the count is unchanged.
  - Full: IDLE does not grant, which stalls all requesters.
  - core_done with the FIFO empty: no pop, err<=1 (sticky until reset), done_id holds its previous value, done still pulses.
- Done reporting: done and done_id are registered and appear 1 cycle after core_done. done_id equals the tag at the FIFO head when the pop occurs. Ordering is FIFO, which matches the core's in-order completion.
- Widths: beat_cnt is 3 bits; its wrap at 7 marks block end. FIFO pointers are log2(TAGD)+1 bits.

Test Plan:
- Single block: ch2 holds s_tvalid for 8 rows, core_ready=1, core_done pulsed 10 cycles later.
  - Required: grant=2 after 1 IDLE cycle, exactly 8 beats, then state returns to IDLE.
  - Required: done=1 with done_id=2 one cycle after core_done; busy falls on the next cycle.
- All 4 channels request continuously for 8 blocks.
  - Required: grant sequence 0,1,2,3,0,1,2,3.
  - Required: done_id sequence identical, and each burst is exactly 8 beats.
- Backpressure: core_ready toggles 1,0 every cycle during a ch1 burst.
  - Required: 8 beats over 15 cycles, s_tready[1] mirrors core_ready, s_tready[0,2,3]=0 throughout.
- FIFO full: TAGD=2, core_done withheld, 3 blocks pending.
  - Required: after 2 blocks, s_tready stays 0 and no grant is made.
  - Required: one core_done pulse releases the 3rd block, and done_id reports the first block's channel.
- Mid-block reset: reset_n=0 after 4 beats of ch3.
  - Required: all outputs 0, and the next arbitration starts from ch0 (last=NCH-1).
  - Required: a spurious core_done on an empty FIFO sets err=1 and done_id stays 0.
